conv_mac_pipe: RTL

Pipelined, parametrised successor to the combinational 3x3 convolution dot-product. It accepts one KERNEL_SIZE×KERNEL_SIZE patch/weight pair per cycle through a valid/ready handshake. It accumulates IN_CH consecutive pairs (one per input channel) plus a bias into a single output-pixel result. Signed mode and optional ReLU are supported. It sits between the line-buffer/patch extractor and the output writer.

---
 rtl/conv_mac_pipe.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/conv_mac_pipe.sv
// -----------------------------------------------------------------------------
// conv_mac_pipe
//
// Three-stage pipelined convolution MAC. Each accepted beat carries one
// KERNEL_SIZE x KERNEL_SIZE patch/weight pair for one input channel. IN_CH
// consecutive beats, plus a bias taken from the channel-0 beat, are summed
// into a single output pixel.
//
//   stage 1 : N tap products, first/last channel tags, bias
//   stage 2 : extended sum of the N products
//   stage 3 : channel accumulation, optional ReLU, registered RESULT
//
// Ports
//   CLK        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   PATCH/KERNEL/BIAS valid
//   in_ready   beat can be accepted (= global pipeline enable)
//   PATCH      N taps, tap i at [i*DATA_W +: DATA_W]
//   KERNEL     N weights, same packing as PATCH
//   BIAS       bias, used only on a channel-0 beat
//   out_valid  RESULT valid
//   out_ready  downstream accepts RESULT
//   RESULT     registered output pixel
//   ch_idx     channel index of the next beat to be accepted
// -----------------------------------------------------------------------------
module conv_mac_pipe #(
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_W      = 16,
  parameter int IN_CH       = 4,
  parameter int SIGNED      = 0,
  parameter int RELU        = 0,
  parameter int OUT_W       = 64,
  localparam int N          = KERNEL_SIZE * KERNEL_SIZE,
  localparam int CH_W       = (IN_CH > 1) ? $clog2(IN_CH) : 1
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*DATA_W-1:0]   PATCH,
  input  logic [N*DATA_W-1:0]   KERNEL,
  input  logic [OUT_W-1:0]      BIAS,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      RESULT,
  output logic [CH_W-1:0]       ch_idx
);

  localparam int              PW      = 2 * DATA_W;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(IN_CH - 1);

  // Operand extension to product width: the low PW bits of the product of two
  // extended operands are the exact signed/unsigned product.
  function automatic logic [PW-1:0] ext_tap(input logic [DATA_W-1:0] v);
    if (SIGNED != 0) ext_tap = {{DATA_W{v[DATA_W-1]}}, v};
    else             ext_tap = {{DATA_W{1'b0}}, v};
  endfunction

  function automatic logic [OUT_W-1:0] ext_prod(input logic [PW-1:0] p);
    if (SIGNED != 0) ext_prod = {{(OUT_W-PW){p[PW-1]}}, p};
    else             ext_prod = {{(OUT_W-PW){1'b0}}, p};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic              en, accept;

  logic [CH_W-1:0]   ch_q, ch_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_first_q, s1_first_d;
  logic              s1_last_q,  s1_last_d;
  logic              s2_valid_q, s2_valid_d;
  logic              s2_first_q, s2_first_d;
  logic              s2_last_q,  s2_last_d;
  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  acc_q, acc_d;
  logic [OUT_W-1:0]  result_q, result_d;

  logic [PW-1:0]     prod_q [N];
  logic [PW-1:0]     prod_d [N];
  logic [OUT_W-1:0]  s1_bias_q, s1_bias_d;
  logic [OUT_W-1:0]  s2_bias_q, s2_bias_d;
  logic [OUT_W-1:0]  s2_sum_q,  s2_sum_d;
  logic [OUT_W-1:0]  tap_sum;
  logic [OUT_W-1:0]  acc_base, acc_nxt;

  // A stalled output freezes the whole pipeline, so in_ready is the enable.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  // ---------------------------------------------------------------------------
  // Stage 1: products, channel tags, bias; channel counter
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    ch_d       = ch_q;
    s1_valid_d = s1_valid_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    s1_bias_d  = s1_bias_q;
    prod_d     = prod_q;

    if (accept) ch_d = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;

    if (en) begin
      s1_valid_d = accept;
      s1_first_d = (ch_q == '0);
      s1_last_d  = (ch_q == LAST_CH);
      s1_bias_d  = BIAS;
      for (int i = 0; i < N; i++)
        prod_d[i] = ext_tap(PATCH[i*DATA_W +: DATA_W]) *
                    ext_tap(KERNEL[i*DATA_W +: DATA_W]);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: tap sum
  // ---------------------------------------------------------------------------
  always_comb begin
    tap_sum = '0;
    for (int i = 0; i < N; i++) tap_sum = tap_sum + ext_prod(prod_q[i]);

    s2_valid_d = s2_valid_q;
    s2_first_d = s2_first_q;
    s2_last_d  = s2_last_q;
    s2_bias_d  = s2_bias_q;
    s2_sum_d   = s2_sum_q;
    if (en) begin
      s2_valid_d = s1_valid_q;
      s2_first_d = s1_first_q;
      s2_last_d  = s1_last_q;
      s2_bias_d  = s1_bias_q;
      s2_sum_d   = tap_sum;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: channel accumulation and output register
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_base    = s2_first_q ? s2_bias_q : acc_q;
    acc_nxt     = acc_base + s2_sum_q;   // wraps modulo 2^OUT_W by design

    acc_d       = acc_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    // Bubbles (s2_valid_q == 0) leave the accumulator untouched.
    if (en && s2_valid_q) begin
      if (s2_last_q) begin
        result_d    = (RELU != 0 && SIGNED != 0 && acc_nxt[OUT_W-1]) ? '0 : acc_nxt;
        out_valid_d = 1'b1;
        acc_d       = '0;
      end else begin
        acc_d       = acc_nxt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before this edge, independent of order.
    if (rst) begin
      ch_q        <= '0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      result_q    <= '0;
    end else begin
      ch_q        <= ch_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_first_q  <= s2_first_d;
      s2_last_q   <= s2_last_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
    end
  end

  // NOTE: datapath registers are not reset; they are only consumed while the
  // matching valid bit is set, and leaving them out keeps the reset tree small.
  always_ff @(posedge CLK) begin
    prod_q    <= prod_d;
    s1_bias_q <= s1_bias_d;
    s2_bias_q <= s2_bias_d;
    s2_sum_q  <= s2_sum_d;
  end

  assign out_valid = out_valid_q;
  assign RESULT    = result_q;
  assign ch_idx    = ch_q;

endmodule
